// File: rtl/bcd_display_ctrl_if.sv
// Store-port handshake bundle between the core and the display controller.
//   wr_valid : store strobe, held by the master for as long as it offers wr_data
//   wr_data  : binary value to display
//   wr_ready : the controller can accept a value in this cycle
//   wr_drop  : one-cycle pulse, one cycle after a wr_valid that met wr_ready low
interface bcd_display_ctrl_if;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_ready;
   logic        wr_drop;

   modport master (output wr_valid, output wr_data, input wr_ready, input wr_drop);
   modport slave  (input wr_valid, input wr_data, output wr_ready, output wr_drop);
endinterface

// File: rtl/bcd_display_ctrl.sv
// Four-digit common-anode seven-segment controller fed from the core store port.
// A binary value accepted on the bus is converted to BCD by a 16-step
// double-dabble engine. The result is committed to the display register, and
// the four digits are then time-multiplexed.
//   clk_100mhz     : single clock, rising edge
//   reset          : synchronous, active high
//   bus            : store handshake (slave side)
//   bcd_value      : committed BCD value, thousands digit in [15:12]
//   overflow       : committed binary value was at least 10000
//   frozen         : FINAL_VALUE has been committed; further writes are dropped
//   Anode_Activate : active-low digit enables
//   LED_out        : active-low segments, abcdefg
module bcd_display_ctrl #(
   parameter int unsigned REFRESH_BITS = 20,
   parameter logic [15:0] FINAL_VALUE  = 16'd6765
) (
   input  logic                    clk_100mhz,
   input  logic                    reset,
   bcd_display_ctrl_if.slave       bus,
   output logic [15:0]             bcd_value,
   output logic                    overflow,
   output logic                    frozen,
   output logic [3:0]              Anode_Activate,
   output logic [6:0]              LED_out
);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   localparam logic [REFRESH_BITS-1:0] SCAN_STEP = REFRESH_BITS'(1);

   state_t                  state;
   logic [15:0]             bin;        // shifts out MSB-first into bcd
   logic [15:0]             captured;   // unshifted copy used for the freeze compare
   logic [19:0]             bcd;
   logic [19:0]             bcd_adj;
   logic [3:0]              shift_cnt;
   logic [REFRESH_BITS-1:0] scan;
   logic [1:0]              sel;
   logic [3:0]              digit;
   logic                    accept;

   assign bus.wr_ready = (state == IDLE) && !frozen;
   assign accept       = bus.wr_valid && bus.wr_ready;

   // Add-3 correction on every nibble that would reach 10 or more after the shift
   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < 5; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         state       <= IDLE;
         bin         <= '0;
         captured    <= '0;
         bcd         <= '0;
         shift_cnt   <= '0;
         bcd_value   <= '0;
         overflow    <= 1'b0;
         frozen      <= 1'b0;
         bus.wr_drop <= 1'b0;
      end else begin
         bus.wr_drop <= bus.wr_valid && !bus.wr_ready;
         case (state)
            IDLE: begin
               if (accept) begin
                  bin       <= bus.wr_data;
                  captured  <= bus.wr_data;
                  bcd       <= '0;
                  shift_cnt <= '0;
                  state     <= CONV;
               end
            end
            CONV: begin
               {bcd, bin} <= {bcd_adj, bin} << 1;
               shift_cnt  <= shift_cnt + 4'd1;
               if (shift_cnt == 4'd15) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               bcd_value <= bcd[15:0];
               overflow  <= |bcd[19:16];
               frozen    <= frozen | (captured == FINAL_VALUE);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (reset) begin
         scan <= '0;
      end else begin
         scan <= scan + SCAN_STEP;
      end
   end

   assign sel = scan[REFRESH_BITS-1 -: 2];

   always_comb begin
      Anode_Activate = 4'b1111;
      digit          = '0;
      case (sel)
         2'b00: begin Anode_Activate = 4'b0111; digit = bcd_value[15:12]; end
         2'b01: begin Anode_Activate = 4'b1011; digit = bcd_value[11:8];  end
         2'b10: begin Anode_Activate = 4'b1101; digit = bcd_value[7:4];   end
         default: begin Anode_Activate = 4'b1110; digit = bcd_value[3:0]; end
      endcase
   end

   always_comb begin
      LED_out = 7'b0000001;
      case (digit)
         4'd0: LED_out = 7'b0000001;
         4'd1: LED_out = 7'b1001111;
         4'd2: LED_out = 7'b0010010;
         4'd3: LED_out = 7'b0000110;
         4'd4: LED_out = 7'b1001100;
         4'd5: LED_out = 7'b0100100;
         4'd6: LED_out = 7'b0100000;
         4'd7: LED_out = 7'b0001111;
         4'd8: LED_out = 7'b0000000;
         4'd9: LED_out = 7'b0000100;
         default: LED_out = 7'b0000001;
      endcase
   end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Display controller between the RISC-V core's store port (MemWrite/WriteData) and the 4-digit common-anode seven-segment display.
- Accepts binary store values through a valid/ready handshake and converts them to BCD with a sequential double-dabble engine, replacing combinational divide/modulo.
- Commits the converted value to a display register, freezes on a programmable final value, and time-multiplexes the four digits.

Parameters:
- REFRESH_BITS, 20: width of the free-running scan counter. Digit select is the top 2 bits. Benches use 4.
- FINAL_VALUE, 16'd6765: committed binary value that freezes the display.

Ports:
- clk_100mhz, input, 1: single clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- wr_valid, input, 1: store strobe (MemWrite, synchronised to clk_100mhz).
- wr_data, input, 16: binary value to display (WriteData[15:0]).
- wr_ready, output, 1: the block can accept a value this cycle.
- wr_drop, output, 1: one-cycle pulse when wr_valid is high while wr_ready is low.
- bcd_value, output, 16: committed 4-digit BCD (thousands in [15:12]).
- overflow, output, 1: committed value was at least 10000.
- frozen, output, 1: FINAL_VALUE has been committed.
- Anode_Activate, output, 4: active-low digit enables.
- LED_out, output, 7: active-low segments, ordered abcdefg.

Behaviour:
Reset values:
- FSM is IDLE.
- wr_ready=1, wr_drop=0, bcd_value=0, overflow=0, frozen=0.
- Scan counter is 0, so Anode_Activate=4'b0111 and LED_out=7'b0000001.

Handshake:
- A transfer occurs on an edge where wr_valid=1 and wr_ready=1.
- wr_ready = (state==IDLE) && !frozen, driven combinationally from registered state.
- wr_valid while not ready is discarded, never queued. wr_drop is registered, so it is high in the cycle after the rejected request.

FSM:
- IDLE -> CONV on accept.
  - Load a 16-bit binary shift register with wr_data.
  - Clear the 20-bit BCD accumulator.
  - Clear the 4-bit shift counter.
- CONV, 16 cycles. Each cycle:
  - In every 4-bit BCD nibble, add 3 if the nibble is at least 5.
  - Shift {bcd, bin} left by 1.
  - Increment the counter. After the 16th shift, go to COMMIT.
- COMMIT, 1 cycle:
  - bcd_value <= bcd[15:0] (value mod 10000).
  - overflow <= (bcd[19:16] != 0).
  - frozen <= frozen | (captured binary == FINAL_VALUE).
  - Go to IDLE.

Timing:
- Accept edge = E0. Shifts happen on E1..E16. Commit happens on E17.
- New outputs are visible after E17. wr_ready is low from after E0 until after E17.
- Minimum accept spacing is 18 cycles.

Freeze:
- Once frozen=1, wr_ready stays 0 and every wr_valid pulses wr_drop.
- Only reset clears frozen.
- The freeze compare uses the full 16-bit binary value, not the BCD value.

Scan:
- The REFRESH_BITS counter free-runs and wraps to 0.
- The top 2 bits select the digit:

| sel | Anode_Activate | digit |
|---|---|---|
| 00 | 0111 | bcd_value[15:12] |
| 01 | 1011 | bcd_value[11:8] |
| 10 | 1101 | bcd_value[7:4] |
| 11 | 1110 | bcd_value[3:0] |

- Leading zeros are displayed.
- Anode_Activate and LED_out are combinational from the counter and bcd_value.
- Scanning continues during CONV and always shows the last committed value.

Segment encoding (active low, abcdefg):
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
- Nibbles 10..15 are unreachable and drive 0000001.

Boundaries:
- reset in any state, including mid-CONV or COMMIT: return to reset values next edge and discard the conversion.
- reset together with wr_valid: reset wins and nothing is accepted.
- wr_data=0 converts to 0x0000.
- wr_data=65535 converts to 0x5535 with overflow=1.
- A value at or above 10000 that equals FINAL_VALUE still freezes.

Test Plan:
1. Reset, then wr_valid with 1234 for 1 cycle -> wr_ready=0 for 17 cycles. After E17: bcd_value=0x1234, overflow=0. Over the scan (REFRESH_BITS=4):
   - anode 0111 with 1001111
   - anode 1011 with 0010010
   - anode 1101 with 0000110
   - anode 1110 with 1001100
2. Write 6765 -> bcd_value=0x6765, frozen=1, wr_ready=0. Then write 42 -> wr_drop pulse, bcd_value stays 0x6765. After reset, frozen=0.
3. Write 12345 -> bcd_value=0x2345, overflow=1. Write 65535 -> 0x5535, overflow=1. Write 0 -> 0x0000, overflow=0.
4. Write 1000, then pulse wr_valid with 99 at E5 -> one wr_drop pulse. After E17: bcd_value=0x1000, and 99 never appears.
5. Write 4321, assert reset at E8 -> all outputs at reset values and state IDLE. Then write 7 -> bcd_value=0x0007 after 17 more cycles.
6. Back-to-back: hold wr_valid high with values 11, then 22 presented exactly at the cycle wr_ready rises -> both accepted 18 cycles apart. Final bcd_value=0x0022, with no wr_drop while ready.
